fht_frame_ctrl: RTL

- Frame sequencer in front of fht_top.
- Captures a stream of ADC samples into the four input RAM banks, using bit-reversed bank order, then pulses the FHT start.
- Waits for FHT completion, guarded by a timeout, and holds the result until the host releases it.
- Replaces the bench-driven write/start sequence with synthesizable control.

---
 rtl/fht_pkg.sv | 18 +
 rtl/fht_frame_ctrl_if.sv | 22 ++
 rtl/fht_wr_addr_gen.sv | 40 ++++
 rtl/fht_frame_ctrl.sv | 72 +++++++
 4 files changed

// File: rtl/fht_pkg.sv
// fht_pkg: shared frame-sequencer types, default widths and bank-order helper.
package fht_pkg;
   localparam int DEF_A_BIT = 7;
   localparam int DEF_D_BIT = 16;
   localparam int BANK_SIZE = 2 ** DEF_A_BIT;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } fht_frame_state_t;
   // Bit-reversed bank index as a one-hot write enable: bank order 0, 2, 1, 3.
   function automatic logic [3:0] bank_bitrev(input logic [1:0] b);
      return 4'b0001 << {b[0], b[1]};
   endfunction
endpackage

// File: rtl/fht_frame_ctrl_if.sv
// fht_frame_ctrl_if: host, ADC and FHT-side signals of the frame sequencer.
interface fht_frame_ctrl_if
   import fht_pkg::*;
#(
   parameter int A_BIT = DEF_A_BIT,
   parameter int D_BIT = DEF_D_BIT
);
   logic arm, adc_valid, rdy, rel;
   logic [D_BIT-2:0] adc_data, data;
   logic [A_BIT-1:0] addr_wr;
   logic [3:0] we;
   logic start, busy, frame_rdy, ovf, err;
   fht_frame_state_t state;
   modport master (
      input  arm, adc_valid, adc_data, rdy, rel,
      output data, addr_wr, we, start, busy, frame_rdy, ovf, err, state
   );
   modport slave (
      output arm, adc_valid, adc_data, rdy, rel,
      input  data, addr_wr, we, start, busy, frame_rdy, ovf, err, state
   );
endinterface

// File: rtl/fht_wr_addr_gen.sv
// fht_wr_addr_gen: bank/address counters, bit-reversed write enables, last-sample flag.
module fht_wr_addr_gen
   import fht_pkg::*;
#(
   parameter int A_BIT = DEF_A_BIT,
   parameter int D_BIT = DEF_D_BIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [D_BIT-2:0] sample,
   output logic [D_BIT-2:0] data,
   output logic [A_BIT-1:0] addr,
   output logic [3:0]       we,
   output logic             last
);
   logic [A_BIT-1:0] cnt_addr;
   logic [1:0]       cnt_bank;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_addr <= '0;
         cnt_bank <= '0;
         data     <= '0;
         addr     <= '0;
         we       <= '0;
         last     <= 1'b0;
      end else begin
         if (clr) {cnt_bank, cnt_addr} <= '0;
         else if (en) {cnt_bank, cnt_addr} <= {cnt_bank, cnt_addr} + 1'b1;
         if (en) begin
            data <= sample;
            addr <= cnt_addr;
         end
         we   <= en ? bank_bitrev(cnt_bank) : 4'b0000;
         // Pulses together with the final write enable of the frame.
         last <= en && (&{cnt_bank, cnt_addr});
      end
   end
endmodule

// File: rtl/fht_frame_ctrl.sv
// fht_frame_ctrl: captures an ADC frame into the FHT banks, starts the FHT and tracks completion.
module fht_frame_ctrl
   import fht_pkg::*;
#(
   parameter int A_BIT       = DEF_A_BIT,
   parameter int D_BIT       = DEF_D_BIT,
   parameter int GUARD_CYC   = 2,
   parameter int TIMEOUT_CYC = 65535,
   parameter bit AUTO_REARM  = 1'b0
) (
   input logic              clk,
   input logic              rst,
   fht_frame_ctrl_if.master bus
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int GW = $clog2(GUARD_CYC + 2);
   fht_frame_state_t state, state_n;
   logic [GW-1:0] guard;
   logic [TW-1:0] tmo;
   logic last, wr_en, arm_go, busy, ovf, err;
   assign wr_en  = bus.adc_valid && state == LOAD && !last;
   assign arm_go = state_n == LOAD && state != LOAD;
   fht_wr_addr_gen #(.A_BIT(A_BIT), .D_BIT(D_BIT)) u_wr (
      .clk    (clk),
      .rst    (rst),
      .clr    (state != LOAD),
      .en     (wr_en),
      .sample (bus.adc_data),
      .data   (bus.data),
      .addr   (bus.addr_wr),
      .we     (bus.we),
      .last   (last)
   );
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    state_n = bus.arm ? LOAD : IDLE;
         LOAD:    state_n = last ? START : LOAD;
         START:   state_n = RUN;
         // A ready after the guard beats a coincident timeout.
         RUN:     state_n = (bus.rdy && guard == '0) ? DONE :
                            (tmo == TW'(TIMEOUT_CYC - 1)) ? ERROR : RUN;
         DONE:    state_n = !bus.rel ? DONE : (AUTO_REARM || bus.arm) ? LOAD : IDLE;
         ERROR:   state_n = bus.arm ? LOAD : ERROR;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         guard <= '0;
         tmo   <= '0;
         busy  <= 1'b0;
         ovf   <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= state_n != IDLE;
         if (state == START) guard <= GW'(GUARD_CYC);
         else if (guard != '0) guard <= guard - 1'b1;
         tmo   <= (state == RUN) ? tmo + 1'b1 : '0;
         ovf   <= (bus.adc_valid && state != LOAD) ? 1'b1 : arm_go ? 1'b0 : ovf;
         err   <= (state_n == ERROR) ? 1'b1 : arm_go ? 1'b0 : err;
      end
   end
   assign bus.start     = state == START;
   assign bus.frame_rdy = state == DONE;
   assign bus.busy      = busy;
   assign bus.ovf       = ovf;
   assign bus.err       = err;
   assign bus.state     = state;
endmodule
